// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flexible FIFO: ceiling log2 and the derived
// widths of the occupancy counter and the ring pointers.
package fifo_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

    // The counter must hold the value L itself, so it needs clog2(L+1) bits.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Ring pointer for a FIFO of L entries: advances on inc, wraps from L-1 to 0,
// and returns to 0 on a synchronous clr.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int L = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    inc,
    input  logic                    clr,
    output logic [ptr_width(L)-1:0] ptr
);

    localparam int PW = ptr_width(L);
    localparam logic [PW-1:0] LAST = PW'(L - 1);

    // Explicit wrap compare so non-power-of-two depths never reach index L.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_flex.sv
// Ring-buffer FIFO with req/ack handshakes on both sides, optional fall-through
// when empty, synchronous flush and almost-full / almost-empty flags.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DW     = 8,
    parameter int L      = 4,
    parameter int BYPASS = 0,
    parameter int AF_TH  = L - 1,
    parameter int AE_TH  = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush,
    input  logic [DW-1:0]             d_in,
    input  logic                      req_in,
    output logic                      ack_in,
    output logic [DW-1:0]             d_out,
    output logic                      req_out,
    input  logic                      ack_out,
    output logic [count_width(L)-1:0] count,
    output logic                      afull,
    output logic                      aempty
);

    localparam int CW = count_width(L);
    localparam int PW = ptr_width(L);
    localparam logic [CW-1:0] FULL_LVL = CW'(L);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_TH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_TH);

    logic [DW-1:0] mem [L];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          empty;
    logic          bypass_mode;
    logic          push_xfer;
    logic          pop_xfer;
    logic          push_st;
    logic          pop_st;

    assign empty       = (count == '0);
    assign bypass_mode = (BYPASS != 0) && empty;

    // ack_in looks only at the count register, never at ack_out, so a full
    // FIFO refuses a write even in a cycle where a pop frees an entry.
    assign ack_in  = (count != FULL_LVL) & ~flush;
    assign req_out = bypass_mode ? (req_in & ~flush) : (~empty & ~flush);
    assign d_out   = bypass_mode ? d_in : mem[rp];

    assign push_xfer = req_in & ack_in;
    assign pop_xfer  = req_out & ack_out;

    // A word that falls straight through in bypass mode touches no storage.
    assign push_st = push_xfer & ~(bypass_mode & pop_xfer);
    assign pop_st  = pop_xfer & ~bypass_mode;

    assign afull  = (count >= AF_LVL);
    assign aempty = (count <= AE_LVL);

    fifo_ptr #(.L(L)) u_wp (
        .clk  (clk),
        .rstn (rstn),
        .inc  (push_st),
        .clr  (flush),
        .ptr  (wp)
    );

    fifo_ptr #(.L(L)) u_rp (
        .clk  (clk),
        .rstn (rstn),
        .inc  (pop_st),
        .clr  (flush),
        .ptr  (rp)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push_st, pop_st})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (push_st) begin
            mem[wp] <= d_in;
        end
    end

endmodule

// File: tb/tb_fifo_flex.sv
// Self-checking bench for fifo_flex: a registered L=4 instance and a bypass
// L=3 instance driven side by side against a queue-based reference model.
module tb_fifo_flex;

    localparam int LA  = 4;
    localparam int LB  = 3;
    localparam int AFA = LA - 1;
    localparam int AEA = 1;
    localparam int AFB = 2;
    localparam int AEB = 0;

    logic       clk;
    logic       rstn;

    logic       flush_a, req_in_a, ack_in_a, req_out_a, ack_out_a, afull_a, aempty_a;
    logic [7:0] d_in_a, d_out_a;
    logic [2:0] count_a;

    logic       flush_b, req_in_b, ack_in_b, req_out_b, ack_out_b, afull_b, aempty_b;
    logic [7:0] d_in_b, d_out_b;
    logic [1:0] count_b;

    logic [7:0] model_q [2][$];
    int         n_compared;
    int         n_mismatched;

    fifo_flex #(.DW(8), .L(LA), .BYPASS(0), .AF_TH(AFA), .AE_TH(AEA)) u_dut_a (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush_a),
        .d_in    (d_in_a),
        .req_in  (req_in_a),
        .ack_in  (ack_in_a),
        .d_out   (d_out_a),
        .req_out (req_out_a),
        .ack_out (ack_out_a),
        .count   (count_a),
        .afull   (afull_a),
        .aempty  (aempty_a)
    );

    fifo_flex #(.DW(8), .L(LB), .BYPASS(1), .AF_TH(AFB), .AE_TH(AEB)) u_dut_b (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush_b),
        .d_in    (d_in_b),
        .req_in  (req_in_b),
        .ack_in  (ack_in_b),
        .d_out   (d_out_b),
        .req_out (req_out_b),
        .ack_out (ack_out_b),
        .count   (count_b),
        .afull   (afull_b),
        .aempty  (aempty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared = n_compared + 1;
        if (observed !== expected) begin
            n_mismatched = n_mismatched + 1;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected outputs follow from the occupancy of a plain queue; the queue
    // is then advanced by whatever transfers the handshake rules allow.
    task automatic checkSide(input int s, input int depth, input bit byp, input int af_th, input int ae_th,
                             input logic fl, input logic rq, input logic [7:0] d, input logic ak,
                             input logic [7:0] cnt_obs, input logic ack_in_obs, input logic req_out_obs,
                             input logic [7:0] dout_obs, input logic af_obs, input logic ae_obs);
        string side;
        int    cnt;
        logic  exp_ack_in;
        logic  exp_req_out;
        logic  [7:0] exp_dout;
        bit    through;
        side = (s == 0) ? "A" : "B";
        cnt = model_q[s].size();
        exp_ack_in = (cnt != depth) && !fl;
        through = byp && (cnt == 0);
        if (through) begin
            exp_req_out = rq && !fl;
            exp_dout = d;
        end else begin
            exp_req_out = (cnt != 0) && !fl;
            exp_dout = (cnt != 0) ? model_q[s][0] : 8'h00;
        end
        checkOutput($sformatf("%s_count", side), 32'(cnt_obs), 32'(cnt));
        checkOutput($sformatf("%s_ack_in", side), 32'(ack_in_obs), 32'(exp_ack_in));
        checkOutput($sformatf("%s_req_out", side), 32'(req_out_obs), 32'(exp_req_out));
        checkOutput($sformatf("%s_afull", side), 32'(af_obs), 32'(cnt >= af_th));
        checkOutput($sformatf("%s_aempty", side), 32'(ae_obs), 32'(cnt <= ae_th));
        if (exp_req_out) begin
            checkOutput($sformatf("%s_d_out", side), 32'(dout_obs), 32'(exp_dout));
        end
        if (fl) begin
            model_q[s].delete();
        end else begin
            if (exp_req_out && ak && !through) begin
                void'(model_q[s].pop_front());
            end
            if (rq && exp_ack_in && !(through && ak)) begin
                model_q[s].push_back(d);
            end
        end
    endtask

    task automatic applyStimulus(input logic fa, input logic ra, input logic [7:0] da, input logic aa,
                                 input logic fb, input logic rb, input logic [7:0] db, input logic ab);
        @(negedge clk);
        flush_a = fa; req_in_a = ra; d_in_a = da; ack_out_a = aa;
        flush_b = fb; req_in_b = rb; d_in_b = db; ack_out_b = ab;
        #1;
        checkSide(0, LA, 1'b0, AFA, AEA, fa, ra, da, aa,
                  8'(count_a), ack_in_a, req_out_a, d_out_a, afull_a, aempty_a);
        checkSide(1, LB, 1'b1, AFB, AEB, fb, rb, db, ab,
                  8'(count_b), ack_in_b, req_out_b, d_out_b, afull_b, aempty_b);
    endtask

    task automatic idleInputs();
        flush_a = 1'b0; req_in_a = 1'b0; d_in_a = 8'h00; ack_out_a = 1'b0;
        flush_b = 1'b0; req_in_b = 1'b0; d_in_b = 8'h00; ack_out_b = 1'b0;
    endtask

    // Short reset pulse between edges: outputs must clear without a clock.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        idleInputs();
        #1;
        rstn = 1'b0;
        #1;
        checkOutput({tag, "_A_count"}, 32'(count_a), 32'd0);
        checkOutput({tag, "_A_req_out"}, 32'(req_out_a), 32'd0);
        checkOutput({tag, "_A_ack_in"}, 32'(ack_in_a), 32'd1);
        checkOutput({tag, "_A_aempty"}, 32'(aempty_a), 32'd1);
        checkOutput({tag, "_B_count"}, 32'(count_b), 32'd0);
        checkOutput({tag, "_B_req_out"}, 32'(req_out_b), 32'd0);
        model_q[0].delete();
        model_q[1].delete();
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        idleInputs();
        req_in_b = 1'b1;
        d_in_b = 8'h3C;
        rstn = 1'b0;
        #1;
        checkOutput("rst_A_count", 32'(count_a), 32'd0);
        checkOutput("rst_A_ack_in", 32'(ack_in_a), 32'd1);
        checkOutput("rst_A_req_out", 32'(req_out_a), 32'd0);
        checkOutput("rst_A_afull", 32'(afull_a), 32'd0);
        checkOutput("rst_A_aempty", 32'(aempty_a), 32'd1);
        checkOutput("rst_B_req_out", 32'(req_out_b), 32'd1);
        checkOutput("rst_B_d_out", 32'(d_out_b), 32'h3C);
        idleInputs();
        @(negedge clk);
        @(negedge clk);
        #2;
        rstn = 1'b1;

        // Fill A without reading, then full-with-pop, then drain.
        applyStimulus(0, 1, 8'h11, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h22, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h33, 0, 0, 0, 8'h00, 0);
        checkOutput("A_afull_at_3", 32'(afull_a), 32'd0);
        applyStimulus(0, 1, 8'h44, 0, 0, 0, 8'h00, 0);
        checkOutput("A_afull_after_3", 32'(afull_a), 32'd1);
        applyStimulus(0, 1, 8'h55, 1, 0, 0, 8'h00, 0);
        checkOutput("A_full_count", 32'(count_a), 32'd4);
        checkOutput("A_full_ack_in", 32'(ack_in_a), 32'd0);
        checkOutput("A_full_d_out", 32'(d_out_a), 32'h11);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        checkOutput("A_after_refuse", 32'(count_a), 32'd3);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);

        // Bypass pass-through on empty B, then a stored word on B.
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'hA5, 1);
        checkOutput("B_bypass_d_out", 32'(d_out_b), 32'hA5);
        applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'h5A, 0);
        checkOutput("B_bypass_count", 32'(count_b), 32'd0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);

        // L=3 continuous streaming through the stored path wraps pointers.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 0, 1, 8'(8'h80 + i), 1);
        end
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 8'h00, 1);

        // Flush with a concurrent push drops everything.
        applyStimulus(0, 1, 8'h61, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 8'h62, 0, 0, 0, 8'h00, 0);
        applyStimulus(1, 1, 8'h63, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        checkOutput("A_flush_count", 32'(count_a), 32'd0);
        checkOutput("A_flush_aempty", 32'(aempty_a), 32'd1);

        // Asynchronous reset with three stored words, then a fresh push.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'(8'h70 + i), 0, 0, 1, 8'(8'h90 + i), 0);
        pulseReset("mid");
        applyStimulus(0, 1, 8'h7E, 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 0, 8'h00, 1, 0, 0, 8'h00, 0);
        checkOutput("A_after_reset_d_out", 32'(d_out_a), 32'h7E);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 40) == 0), ($urandom_range(0, 1) == 1), 8'($urandom),
                          ($urandom_range(0, 1) == 1));
            if (i == 300) pulseReset("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
